// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a response requester and a dump requester, one-deep buffer each.
// Latency: request to trmt is 2 clocks from idle; tx_done to next trmt is 2 clocks.
// Backpressure: none upstream; a request hitting a full buffer is dropped and flagged sticky.
module uart_tx_arbiter #(
    parameter int MAX_SKIP   = 4,
    parameter int TX_TIMEOUT = 16384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       resp_req,
    input  logic [7:0] resp_data,
    output logic       resp_sent,
    input  logic       dump_req,
    input  logic [7:0] dump_data,
    output logic       dump_sent,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       clr_err,
    output logic       busy,
    output logic       ovfl_resp,
    output logic       ovfl_dump,
    output logic       tx_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  MAX_SKIP_V = 4'(MAX_SKIP);
    localparam logic [15:0] TMO_LAST   = 16'(TX_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;

    logic        pend_resp;
    logic        pend_dump;
    logic [7:0]  resp_buf;
    logic [7:0]  dump_buf;
    logic        owner_dump;
    logic [3:0]  skip_cnt;
    logic [15:0] tmo_cnt;

    logic        any_pend;
    logic        load_go;
    logic        grant_dump;
    logic        grant_resp;
    logic        take_resp;
    logic        take_dump;
    logic        done_ok;
    logic        tmo_abort;

    // Arbitration and capture decisions
    always_comb begin
        any_pend   = pend_resp | pend_dump;
        load_go    = (state == IDLE) && any_pend;
        grant_dump = pend_dump && (!pend_resp || (skip_cnt >= MAX_SKIP_V));
        grant_resp = load_go && !grant_dump;
        // A buffer being handed to LOAD on this edge can accept a new byte at once
        take_resp  = resp_req && (!pend_resp || grant_resp);
        take_dump  = dump_req && (!pend_dump || (load_go && grant_dump));
        done_ok    = (state == WAIT) && tx_done;
        tmo_abort  = (state == WAIT) && !tx_done && (tmo_cnt == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (done_ok || tmo_abort) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        trmt = (state == LOAD);
        busy = (state != IDLE) || any_pend;
    end

    // Capture buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_resp <= 1'b0;
            pend_dump <= 1'b0;
            resp_buf  <= 8'h00;
            dump_buf  <= 8'h00;
        end else begin
            if (take_resp) begin
                resp_buf  <= resp_data;
                pend_resp <= 1'b1;
            end else if (grant_resp) begin
                pend_resp <= 1'b0;
            end
            if (take_dump) begin
                dump_buf  <= dump_data;
                pend_dump <= 1'b1;
            end else if (load_go && grant_dump) begin
                pend_dump <= 1'b0;
            end
        end
    end

    // Grant bookkeeping and transmit datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data    <= 8'h00;
            owner_dump <= 1'b0;
            skip_cnt   <= 4'd0;
            tmo_cnt    <= 16'd0;
            resp_sent  <= 1'b0;
            dump_sent  <= 1'b0;
        end else begin
            if (load_go) begin
                tx_data    <= grant_dump ? dump_buf : resp_buf;
                owner_dump <= grant_dump;
                // The skip count only matters while a dump byte is actually waiting
                if (grant_dump || !pend_dump) begin
                    skip_cnt <= 4'd0;
                end else begin
                    skip_cnt <= skip_cnt + 4'd1;
                end
            end
            if (state == LOAD) begin
                tmo_cnt <= 16'd0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            resp_sent <= done_ok && !owner_dump;
            dump_sent <= done_ok && owner_dump;
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err takes precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl_resp <= 1'b0;
            ovfl_dump <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            ovfl_resp <= (ovfl_resp && !clr_err) || (resp_req && !take_resp);
            ovfl_dump <= (ovfl_dump && !clr_err) || (dump_req && !take_dump);
            tx_err    <= (tx_err && !clr_err) || tmo_abort;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes queued at stimulus, compared as trmt fires.
module tb_uart_tx_arbiter;

    localparam int TMO = 128;

    logic       clk;
    logic       rst_n;
    logic       resp_req;
    logic [7:0] resp_data;
    logic       resp_sent;
    logic       dump_req;
    logic [7:0] dump_data;
    logic       dump_sent;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       clr_err;
    logic       busy;
    logic       ovfl_resp;
    logic       ovfl_dump;
    logic       tx_err;

    typedef struct {
        bit         dump;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   resp_cnt = 0;
    int   dump_cnt = 0;

    uart_tx_arbiter #(.MAX_SKIP(4), .TX_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp_req  (resp_req),
        .resp_data (resp_data),
        .resp_sent (resp_sent),
        .dump_req  (dump_req),
        .dump_data (dump_data),
        .dump_sent (dump_sent),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .clr_err   (clr_err),
        .busy      (busy),
        .ovfl_resp (ovfl_resp),
        .ovfl_dump (ovfl_dump),
        .tx_err    (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_sent) resp_cnt++;
        if (dump_sent) dump_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One-cycle request pulse(s), driven and released on negedges
    task automatic drive_req(input bit r, input logic [7:0] rd, input bit d, input logic [7:0] dd);
        resp_req  = r;
        resp_data = rd;
        dump_req  = d;
        dump_data = dd;
        @(negedge clk);
        resp_req = 1'b0;
        dump_req = 1'b0;
    endtask

    // Returns number of negedges waited until trmt seen, or -1 on expiry
    task automatic wait_trmt(input int limit, output int n);
        n = -1;
        for (int i = 0; i < limit; i++) begin
            if (trmt) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({trmt, tx_data, resp_sent, dump_sent, busy, ovfl_resp, ovfl_dump, tx_err} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h want=0",
                     {trmt, tx_data, resp_sent, dump_sent, busy, ovfl_resp, ovfl_dump, tx_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_done();
        total++;
        if ({resp_sent, dump_sent, busy, trmt} !== 4'd0) begin
            bad++;
            $display("FAIL idle_tx_done got=%0b want=0000", {resp_sent, dump_sent, busy, trmt});
        end
    endtask

    task automatic test_single();
        int   n;
        exp_t e;
        sb.push_back('{1'b0, 8'hA5});
        drive_req(1'b1, 8'hA5, 1'b0, 8'h00);
        wait_trmt(20, n);
        total++;
        if (n + 1 !== 2) begin
            bad++;
            $display("FAIL single_latency got=%0d want=2", n + 1);
        end
        e = sb.pop_front();
        total++;
        if (tx_data !== e.data) begin
            bad++;
            $display("FAIL single_data got=%0h want=%0h", tx_data, e.data);
        end
        @(negedge clk);
        total++;
        if (trmt !== 1'b0) begin
            bad++;
            $display("FAIL single_trmt_width got=%0b want=0", trmt);
        end
        repeat (98) @(negedge clk);
        pulse_done();
        total++;
        if ({resp_sent, dump_sent} !== {!e.dump, e.dump}) begin
            bad++;
            $display("FAIL single_sent got=%0b want=%0b", {resp_sent, dump_sent}, {!e.dump, e.dump});
        end
        @(negedge clk);
        total++;
        if ({resp_sent, busy, tx_data} !== {1'b0, 1'b0, 8'hA5}) begin
            bad++;
            $display("FAIL single_after got=%0h want=%0h", {resp_sent, busy, tx_data}, {2'b00, 8'hA5});
        end
    endtask

    task automatic test_simultaneous();
        int   n;
        int   d0;
        exp_t e;
        d0 = dump_cnt;
        sb.push_back('{1'b0, 8'h11});
        sb.push_back('{1'b1, 8'h22});
        drive_req(1'b1, 8'h11, 1'b1, 8'h22);
        for (int k = 0; k < 2; k++) begin
            wait_trmt(20, n);
            if (k == 1) begin
                total++;
                if (n !== 1) begin
                    bad++;
                    $display("FAIL simul_gap got=%0d want=1", n);
                end
            end
            e = sb.pop_front();
            total++;
            if (tx_data !== e.data) begin
                bad++;
                $display("FAIL simul_data%0d got=%0h want=%0h", k, tx_data, e.data);
            end
            repeat (5) @(negedge clk);
            pulse_done();
            total++;
            if ({resp_sent, dump_sent} !== {!e.dump, e.dump}) begin
                bad++;
                $display("FAIL simul_sent%0d got=%0b want=%0b", k, {resp_sent, dump_sent}, {!e.dump, e.dump});
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if ((dump_cnt - d0) !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL simul_dump_once got=%0d/%0b want=1/0", dump_cnt - d0, busy);
        end
    endtask

    task automatic test_starvation();
        int   n;
        exp_t e;
        sb.push_back('{1'b0, 8'h80});
        sb.push_back('{1'b0, 8'h81});
        sb.push_back('{1'b0, 8'h82});
        sb.push_back('{1'b0, 8'h83});
        sb.push_back('{1'b1, 8'hD0});
        sb.push_back('{1'b0, 8'h84});
        drive_req(1'b1, 8'h80, 1'b1, 8'hD0);
        for (int i = 0; i < 6; i++) begin
            wait_trmt(20, n);
            total++;
            if (n < 0) begin
                bad++;
                $display("FAIL starve_trmt%0d got=timeout want=trmt", i);
            end
            e = sb.pop_front();
            total++;
            if (tx_data !== e.data) begin
                bad++;
                $display("FAIL starve_data%0d got=%0h want=%0h", i, tx_data, e.data);
            end
            repeat (3) @(negedge clk);
            // Next response byte arrives together with tx_done so it competes at the following grant
            tx_done = 1'b1;
            if (i < 4) begin
                resp_req  = 1'b1;
                resp_data = 8'h81 + 8'(i);
            end
            @(negedge clk);
            tx_done  = 1'b0;
            resp_req = 1'b0;
            total++;
            if ({resp_sent, dump_sent} !== {!e.dump, e.dump}) begin
                bad++;
                $display("FAIL starve_sent%0d got=%0b want=%0b", i, {resp_sent, dump_sent}, {!e.dump, e.dump});
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if ({busy, ovfl_resp, ovfl_dump} !== 3'b000) begin
            bad++;
            $display("FAIL starve_end got=%0b want=000", {busy, ovfl_resp, ovfl_dump});
        end
    endtask

    task automatic test_overflow();
        int   n;
        int   extra;
        exp_t e;
        sb.push_back('{1'b0, 8'h33});
        sb.push_back('{1'b1, 8'h01});
        drive_req(1'b1, 8'h33, 1'b0, 8'h00);
        wait_trmt(20, n);
        e = sb.pop_front();
        total++;
        if (tx_data !== e.data) begin
            bad++;
            $display("FAIL ovfl_resp_data got=%0h want=%0h", tx_data, e.data);
        end
        drive_req(1'b0, 8'h00, 1'b1, 8'h01);
        clr_err = 1'b1;
        drive_req(1'b0, 8'h00, 1'b1, 8'h02);
        clr_err = 1'b0;
        total++;
        if ({ovfl_dump, ovfl_resp} !== 2'b10) begin
            bad++;
            $display("FAIL ovfl_flag got=%0b want=10", {ovfl_dump, ovfl_resp});
        end
        pulse_done();
        wait_trmt(20, n);
        e = sb.pop_front();
        total++;
        if (tx_data !== e.data) begin
            bad++;
            $display("FAIL ovfl_dump_data got=%0h want=%0h", tx_data, e.data);
        end
        repeat (4) @(negedge clk);
        pulse_done();
        total++;
        if (dump_sent !== 1'b1) begin
            bad++;
            $display("FAIL ovfl_dump_sent got=%0b want=1", dump_sent);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (trmt) extra++;
            @(negedge clk);
        end
        total++;
        if (extra !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ovfl_no_second got=%0d/%0b want=0/0", extra, busy);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (ovfl_dump !== 1'b0) begin
            bad++;
            $display("FAIL ovfl_clear got=%0b want=0", ovfl_dump);
        end
    endtask

    task automatic test_timeout();
        int   n;
        int   r0;
        exp_t e;
        r0 = resp_cnt;
        sb.push_back('{1'b0, 8'h5A});
        sb.push_back('{1'b1, 8'h6B});
        drive_req(1'b1, 8'h5A, 1'b1, 8'h6B);
        wait_trmt(20, n);
        e = sb.pop_front();
        total++;
        if (tx_data !== e.data) begin
            bad++;
            $display("FAIL tmo_first_data got=%0h want=%0h", tx_data, e.data);
        end
        repeat (TMO) @(negedge clk);
        total++;
        if (tx_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early got=%0b want=0", tx_err);
        end
        @(negedge clk);
        total++;
        if ({tx_err, resp_sent} !== 2'b10) begin
            bad++;
            $display("FAIL tmo_flag got=%0b want=10", {tx_err, resp_sent});
        end
        wait_trmt(20, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL tmo_relaunch got=%0d want=1", n);
        end
        e = sb.pop_front();
        total++;
        if (tx_data !== e.data) begin
            bad++;
            $display("FAIL tmo_second_data got=%0h want=%0h", tx_data, e.data);
        end
        repeat (2) @(negedge clk);
        pulse_done();
        total++;
        if ({dump_sent, resp_cnt - r0} !== {1'b1, 32'd0}) begin
            bad++;
            $display("FAIL tmo_sent got=%0b/%0d want=1/0", dump_sent, resp_cnt - r0);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (tx_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_clear got=%0b want=0", tx_err);
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        int   extra;
        exp_t e;
        sb.push_back('{1'b0, 8'h44});
        drive_req(1'b1, 8'h44, 1'b0, 8'h00);
        wait_trmt(20, n);
        e = sb.pop_front();
        total++;
        if (tx_data !== e.data) begin
            bad++;
            $display("FAIL rmid_data got=%0h want=%0h", tx_data, e.data);
        end
        drive_req(1'b1, 8'h55, 1'b1, 8'h66);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({trmt, tx_data, resp_sent, dump_sent, busy, ovfl_resp, ovfl_dump, tx_err} !== 15'd0) begin
            bad++;
            $display("FAIL rmid_outputs got=%0h want=0",
                     {trmt, tx_data, resp_sent, dump_sent, busy, ovfl_resp, ovfl_dump, tx_err});
        end
        rst_n = 1'b1;
        sb.delete();
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (trmt || busy) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL rmid_quiet got=%0d want=0", extra);
        end
        sb.push_back('{1'b0, 8'h77});
        drive_req(1'b1, 8'h77, 1'b0, 8'h00);
        wait_trmt(20, n);
        e = sb.pop_front();
        total++;
        if (n !== 1 || tx_data !== e.data) begin
            bad++;
            $display("FAIL rmid_new got=%0d/%0h want=1/%0h", n, tx_data, e.data);
        end
        repeat (2) @(negedge clk);
        pulse_done();
        total++;
        if (resp_sent !== 1'b1) begin
            bad++;
            $display("FAIL rmid_sent got=%0b want=1", resp_sent);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        resp_req  = 1'b0;
        resp_data = 8'h00;
        dump_req  = 1'b0;
        dump_data = 8'h00;
        tx_done   = 1'b0;
        clr_err   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_starvation();
        test_overflow();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
